// File: rtl/eth_helper_pkg.sv
// Shared definitions for the Ethernet-bound capture stream path.
package eth_helper_pkg;

  localparam int unsigned SRC_WR  = 0;
  localparam int unsigned SRC_RD  = 1;
  localparam int unsigned NUM_SRC = 2;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry register slice: registered output stage plus one skid entry,
// full throughput with in_ready driven only from a flop.
module stream_skid_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             occupied
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             in_fire;
  logic             out_free;

  assign in_ready = !skid_valid;
  assign in_fire  = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;
  assign occupied = out_valid || skid_valid;

  // Output stage refills from the skid entry first so beat order is preserved.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_fire;
        if (in_fire) out_data <= in_data;
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/stream_capture_arbiter.sv
// Packet-granular round-robin arbiter merging the write- and read-channel
// capture streams onto one AXI-Stream master through a skid buffer.
module stream_capture_arbiter
  import eth_helper_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ID_WIDTH   = 32,
  parameter int unsigned DEST_WIDTH = 32,
  parameter int unsigned USER_WIDTH = 64,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [2*DATA_WIDTH-1:0]        src_tdata,
  input  logic [2*ID_WIDTH-1:0]          src_tid,
  input  logic [2*DEST_WIDTH-1:0]        src_tdest,
  input  logic [2*(DATA_WIDTH/8)-1:0]    src_tstrb,
  input  logic [2*(DATA_WIDTH/8)-1:0]    src_tkeep,
  input  logic [2*USER_WIDTH-1:0]        src_tuser,
  input  logic [1:0]                     src_tlast,
  input  logic [1:0]                     src_tvalid,
  output logic [1:0]                     src_tready,
  output logic [ID_WIDTH-1:0]            stream_tid,
  output logic [DEST_WIDTH-1:0]          stream_tdest,
  output logic [DATA_WIDTH-1:0]          stream_tdata,
  output logic [DATA_WIDTH/8-1:0]        stream_tstrb,
  output logic [DATA_WIDTH/8-1:0]        stream_tkeep,
  output logic                           stream_tlast,
  output logic [USER_WIDTH-1:0]          stream_tuser,
  output logic                           stream_tvalid,
  input  logic                           stream_tready,
  output logic                           busy,
  output logic [1:0]                     grant,
  output logic [CNT_WIDTH-1:0]           pkt_count_wr,
  output logic [CNT_WIDTH-1:0]           pkt_count_rd
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned PAY_WIDTH  = ID_WIDTH + DEST_WIDTH + DATA_WIDTH
                                     + 2 * STRB_WIDTH + USER_WIDTH + 1;

  arb_state_e           state;
  logic                 owner;
  logic                 last_served;
  logic                 pick;
  logic                 sel_valid;
  logic                 sel_last;
  logic [PAY_WIDTH-1:0] sel_payload;
  logic                 skid_in_ready;
  logic                 skid_occupied;
  logic                 beat_done;

  // Round-robin choice used only when leaving IDLE.
  always_comb begin
    pick = 1'b0;
    if (src_tvalid[SRC_WR] && src_tvalid[SRC_RD]) pick = !last_served;
    else                                          pick = src_tvalid[SRC_RD];
  end

  // Owner's fields feed the skid buffer; non-owner is held off.
  always_comb begin
    src_tready  = '0;
    sel_valid   = 1'b0;
    sel_last    = 1'b0;
    sel_payload = '0;
    if (state == ARB_GRANT) begin
      src_tready[owner] = skid_in_ready;
      sel_valid         = src_tvalid[owner];
      sel_last          = src_tlast[owner];
    end
    if (owner) begin
      sel_payload = {src_tid[SRC_RD*ID_WIDTH +: ID_WIDTH],
                     src_tdest[SRC_RD*DEST_WIDTH +: DEST_WIDTH],
                     src_tdata[SRC_RD*DATA_WIDTH +: DATA_WIDTH],
                     src_tstrb[SRC_RD*STRB_WIDTH +: STRB_WIDTH],
                     src_tkeep[SRC_RD*STRB_WIDTH +: STRB_WIDTH],
                     src_tuser[SRC_RD*USER_WIDTH +: USER_WIDTH],
                     src_tlast[SRC_RD]};
    end else begin
      sel_payload = {src_tid[SRC_WR*ID_WIDTH +: ID_WIDTH],
                     src_tdest[SRC_WR*DEST_WIDTH +: DEST_WIDTH],
                     src_tdata[SRC_WR*DATA_WIDTH +: DATA_WIDTH],
                     src_tstrb[SRC_WR*STRB_WIDTH +: STRB_WIDTH],
                     src_tkeep[SRC_WR*STRB_WIDTH +: STRB_WIDTH],
                     src_tuser[SRC_WR*USER_WIDTH +: USER_WIDTH],
                     src_tlast[SRC_WR]};
    end
  end

  assign beat_done = sel_valid && skid_in_ready && sel_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ARB_IDLE;
      owner        <= 1'b0;
      grant        <= '0;
      last_served  <= 1'b1;
      pkt_count_wr <= '0;
      pkt_count_rd <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (enable && (|src_tvalid)) begin
            state <= ARB_GRANT;
            owner <= pick;
            grant <= pick ? 2'b10 : 2'b01;
          end
        end
        ARB_GRANT: begin
          if (beat_done) begin
            state       <= ARB_IDLE;
            grant       <= '0;
            last_served <= owner;
            if (owner) pkt_count_rd <= pkt_count_rd + CNT_WIDTH'(1);
            else       pkt_count_wr <= pkt_count_wr + CNT_WIDTH'(1);
          end
        end
        default: begin
          state <= ARB_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  stream_skid_buffer #(
    .WIDTH(PAY_WIDTH)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_valid (sel_valid),
    .in_ready (skid_in_ready),
    .in_data  (sel_payload),
    .out_valid(stream_tvalid),
    .out_ready(stream_tready),
    .out_data ({stream_tid, stream_tdest, stream_tdata, stream_tstrb,
                stream_tkeep, stream_tuser, stream_tlast}),
    .occupied (skid_occupied)
  );

  assign busy = (state == ARB_GRANT) || skid_occupied;

endmodule
